tshift_seq: RTL and testbench

Sequencer for the CAN transmit shift register (`tshiftreg2`). It receives a transmit request from the MAC FSM and computes the frame length from the format, DLC and RTR bit. It then drives the register's `load`, `shift`, `activ` and `reset` inputs, one action per nominal bit time, and signals completion when the last data bit has been sent so the CRC phase can take over.

---
 rtl/tshift_seq.sv | 145 ++++++++++++++
 tb/tb_tshift_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tshift_seq.sv
// tshift_seq: sequencer for the CAN transmit shift register.
// Computes frame length and steps load/shift/activ once per bit time.
module tshift_seq #(
  parameter int CNTW = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            extended,
  input  logic [3:0]      dlc,
  input  logic            rtr,
  input  logic            bittick,
  input  logic            stuffed,
  input  logic            abort,
  output logic            sft_load,
  output logic            sft_shift,
  output logic            sft_activ,
  output logic            sft_reset,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] bitcnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    SEND,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  len_q, len_d;
  logic [CNTW-1:0]  cnt_d, cnt_inc, len_calc;
  logic             pend_q, pend_d;
  logic             pstf_q, pstf_d;
  logic             load_d, shift_d, activ_d;
  logic             rst_d, busy_d, done_d;
  logic             tick_v, stf_v;
  logic [3:0]       nbytes;

  // Frame length from format, DLC and RTR; DLC above 8 clamps to 8 bytes.
  always_comb begin
    nbytes = 4'd0;
    if (!rtr)
      nbytes = (dlc > 4'd8) ? 4'd8 : dlc;
    len_calc = (extended ? CNTW'(39) : CNTW'(19))
             + CNTW'({nbytes, 3'b000});
  end

  assign cnt_inc = bitcnt + CNTW'(1);
  assign tick_v  = pend_q | bittick;
  assign stf_v   = pend_q ? pstf_q : stuffed;

  // Next state and next registered outputs; abort overrides everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = bitcnt;
    pend_d  = pend_q;
    pstf_d  = pstf_q;
    load_d  = 1'b0;
    shift_d = 1'b0;
    done_d  = 1'b0;
    rst_d   = 1'b1;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len_calc;
          cnt_d   = '0;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD, GAP, SHIFT: begin
        state_d = (state_q == GAP) ? SEND : GAP;
        if (bittick && !pend_q) begin
          pend_d = 1'b1;
          pstf_d = stuffed;
        end
      end
      SEND: begin
        if (tick_v) begin
          pend_d = 1'b0;
          if (!stf_v) begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              shift_d = 1'b1;
              state_d = SHIFT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE || start)) begin
      state_d = IDLE;
      len_d   = len_q;
      cnt_d   = bitcnt;
      load_d  = 1'b0;
      shift_d = 1'b0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
      rst_d   = 1'b0;
      busy_d  = 1'b0;
    end
    activ_d = load_d | shift_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      bitcnt    <= '0;
      pend_q    <= 1'b0;
      pstf_q    <= 1'b0;
      sft_load  <= 1'b0;
      sft_shift <= 1'b0;
      sft_activ <= 1'b0;
      sft_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      bitcnt    <= cnt_d;
      pend_q    <= pend_d;
      pstf_q    <= pstf_d;
      sft_load  <= load_d;
      sft_shift <= shift_d;
      sft_activ <= activ_d;
      sft_reset <= rst_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_tshift_seq.sv
// tb_tshift_seq: scoreboard bench for the shift-register sequencer.
// Expected shift/done events are queued at tick time and matched on output.
module tb_tshift_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       extended = 1'b0;
  logic [3:0] dlc = 4'd0;
  logic       rtr = 1'b0;
  logic       bittick = 1'b0;
  logic       stuffed = 1'b0;
  logic       abort = 1'b0;
  logic       sft_load, sft_shift, sft_activ, sft_reset;
  logic       busy, done;
  logic [6:0] bitcnt;

  tshift_seq #(.CNTW(7)) dut (
    .clock(clock), .reset(reset), .start(start),
    .extended(extended), .dlc(dlc), .rtr(rtr),
    .bittick(bittick), .stuffed(stuffed), .abort(abort),
    .sft_load(sft_load), .sft_shift(sft_shift),
    .sft_activ(sft_activ), .sft_reset(sft_reset),
    .busy(busy), .done(done), .bitcnt(bitcnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] kind;
    int         cnt;
    int         cyc;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  nload = 0;
  int  nshift = 0;
  int  exp_loads = 0;
  int  exp_n = 0;
  int  mcnt = 0;
  logic prev_activ = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Output monitor: match events against the scoreboard.
  always @(negedge clock) begin
    ev_t e;
    if (sft_shift || done) begin
      check("unexpected_event", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("event_kind", 32'({done, sft_shift}), 32'(e.kind));
        check("event_bitcnt", 32'(bitcnt), e.cnt);
        check("event_latency", cyc, e.cyc);
      end
    end
    if (done) check("busy_at_done", 32'(busy), 32'd0);
    if (sft_load) nload++;
    if (sft_shift) nshift++;
    check("activ_or", 32'(sft_activ), 32'(sft_load | sft_shift));
    check("activ_consec", 32'(sft_activ & prev_activ), 32'd0);
    prev_activ = sft_activ;
  end

  task automatic start_frame(input logic e, input logic [3:0] d,
                             input logic r, input int n,
                             input int settle);
    exp_n = n;
    mcnt = 0;
    exp_loads++;
    start = 1'b1; extended = e; dlc = d; rtr = r;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (settle) begin @(posedge clock); #1; end
  endtask

  task automatic tick(input logic stf, input int lat);
    ev_t e;
    if (!stf) begin
      mcnt++;
      e.kind = (mcnt == exp_n) ? 2'b10 : 2'b01;
      e.cnt = mcnt;
      e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    bittick = 1'b1; stuffed = stf;
    @(posedge clock); #1;
    bittick = 1'b0; stuffed = 1'b0;
    repeat (lat + 1) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check(tag, sbq.size(), 0);
    check("loads", nload, exp_loads);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       e;
    logic [3:0] d;
    logic       r;
    int         n;
  } len_t;

  len_t lens[3];
  int   s0;

  initial begin
    lens[0] = '{1'b0, 4'd8, 1'b1, 19};
    lens[1] = '{1'b0, 4'd12, 1'b0, 83};
    lens[2] = '{1'b1, 4'd0, 1'b1, 39};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_vals",
          32'({sft_load, sft_shift, sft_activ, sft_reset,
               busy, done, bitcnt}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("sft_reset_rel", 32'(sft_reset), 32'd1);

    // basic dlc=2, with a start while busy
    s0 = nshift;
    start_frame(1'b0, 4'd2, 1'b0, 35, 2);
    check("busy_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 35; i++) begin
      if (i == 10) begin
        start = 1'b1; extended = 1'b1; dlc = 4'd8;
        @(posedge clock); #1;
        start = 1'b0;
      end
      tick(1'b0, 1);
    end
    drain("drain_basic");
    check("shifts_basic", nshift - s0, 34);
    check("bitcnt_basic", 32'(bitcnt), 35);
    check("busy_idle", 32'(busy), 32'd0);

    // extended dlc=8 with stuffed ticks
    s0 = nshift;
    start_frame(1'b1, 4'd8, 1'b0, 103, 2);
    for (int i = 0; i < 108; i++) begin
      if (i == 10 || i == 30 || i == 55 || i == 77 || i == 95) begin
        tick(1'b1, 1);
        check("stuffed_cnt", 32'(bitcnt), mcnt);
      end else begin
        tick(1'b0, 1);
      end
    end
    drain("drain_ext");
    check("shifts_ext", nshift - s0, 102);
    check("bitcnt_ext", 32'(bitcnt), 103);

    // length rules
    foreach (lens[j]) begin
      s0 = nshift;
      start_frame(lens[j].e, lens[j].d, lens[j].r, lens[j].n, 2);
      for (int i = 0; i < lens[j].n; i++) tick(1'b0, 1);
      drain("drain_len");
      check("shifts_len", nshift - s0, lens[j].n - 1);
    end

    // deferred tick on the GAP cycle
    s0 = nshift;
    start_frame(1'b0, 4'd0, 1'b1, 19, 1);
    tick(1'b0, 2);
    for (int i = 1; i < 19; i++) tick(1'b0, 1);
    drain("drain_defer");
    check("shifts_defer", nshift - s0, 18);

    // abort after 40 bits
    start_frame(1'b1, 4'd8, 1'b0, 103, 2);
    for (int i = 0; i < 40; i++) tick(1'b0, 1);
    drain("drain_abort");
    check("bitcnt_pre_abort", 32'(bitcnt), 40);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_rst", 32'(sft_reset), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clock); #1;
    check("abort_rst_end", 32'(sft_reset), 32'd1);
    start_frame(1'b0, 4'd0, 1'b1, 19, 2);
    check("restart_cnt", 32'(bitcnt), 32'd0);
    for (int i = 0; i < 19; i++) tick(1'b0, 1);
    drain("drain_restart");
    check("bitcnt_restart", 32'(bitcnt), 19);

    // start with abort in idle
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    check("sa_load", 32'(sft_load), 32'd0);
    check("sa_rst", 32'(sft_reset), 32'd0);
    check("sa_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    check("loads_sa", nload, exp_loads);

    // reset mid-frame
    start_frame(1'b0, 4'd8, 1'b0, 83, 2);
    for (int i = 0; i < 4; i++) tick(1'b0, 1);
    drain("drain_pre_reset");
    bittick = 1'b1;
    reset = 1'b0;
    @(posedge clock); #1;
    bittick = 1'b0;
    check("midreset_vals",
          32'({sft_load, sft_shift, sft_activ, sft_reset,
               busy, done, bitcnt}), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midreset_rel", 32'(sft_reset), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
